// File: rtl/load_store_unit.sv
// load_store_unit
//   Data-memory access stage behind the multicycle control FSM. It takes one
//   load or store per rising edge of the request level, aligns byte lanes,
//   runs the bus handshake (with wait states and an optional timeout), and
//   returns sign/zero-extended load data with done/error status.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   mem_read            load request level
//   mem_write[3:0]      unshifted store byte mask (0001 SB, 0011 SH, 1111 SW)
//   funct3[2:0]         load width/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
//   addr, store_data    effective address and LSB-justified rs2 value
//   bus_req/we/addr/be/wdata   bus request side, stable until bus_ready
//   bus_ready, bus_rdata       bus response side
//   load_data           extended load result, held until the next completed load
//   done, misaligned, bus_err  one-cycle completion / fault pulses
//   busy                high whenever the unit is not idle
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic [3:0]        mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ready,
    input  logic [31:0]       bus_rdata,
    output logic [31:0]       load_data,
    output logic              done,
    output logic              busy,
    output logic              misaligned,
    output logic              bus_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int              CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int              TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
    localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);

    // Pick the addressed byte/halfword out of the read word and extend it.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            SZ_B:    extend_load = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SZ_H:    extend_load = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: extend_load = word;
        endcase
    endfunction

    logic [1:0]        state, state_nxt;
    logic              req, req_prev, accept;
    logic [CNT_W-1:0]  cnt;
    logic              mis_q, err_q;
    logic              to_hit;

    logic              dec_write, dec_uns, dec_mis;
    logic [1:0]        dec_size;
    logic [3:0]        width_mask, dec_be;
    logic [31:0]       dec_wdata;

    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic              we_q, uns_q;
    logic [1:0]        size_q;

    assign req    = mem_read | (|mem_write);
    assign accept = (state == S_IDLE) && req && !req_prev;

    // Request decode; a store mask takes priority over mem_read.
    always_comb begin
        dec_write = |mem_write;
        dec_uns   = 1'b0;
        dec_size  = SZ_W;
        if (dec_write) begin
            if (mem_write[3])      dec_size = SZ_W;
            else if (mem_write[1]) dec_size = SZ_H;
            else                   dec_size = SZ_B;
        end else begin
            case (funct3)
                3'b000, 3'b100: dec_size = SZ_B;
                3'b001, 3'b101: dec_size = SZ_H;
                default:        dec_size = SZ_W;
            endcase
            dec_uns = funct3[2];
        end
        dec_mis = ((dec_size == SZ_H) && addr[0]) ||
                  ((dec_size == SZ_W) && (addr[1:0] != 2'b00));
        case (dec_size)
            SZ_B:    width_mask = 4'b0001;
            SZ_H:    width_mask = 4'b0011;
            default: width_mask = 4'b1111;
        endcase
        dec_be    = width_mask << addr[1:0];
        dec_wdata = store_data << {addr[1:0], 3'b000};
    end

    // Timeout fires on the TIMEOUT_CYCLES-th consecutive ACCESS cycle without ready.
    assign to_hit = TO_EN && !bus_ready && (cnt == TO_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = dec_mis ? S_DONE : S_ACCESS;
            S_ACCESS: if (bus_ready || to_hit) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Control state: FSM, request edge detect, timeout count, status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            req_prev  <= 1'b0;
            cnt       <= '0;
            mis_q     <= 1'b0;
            err_q     <= 1'b0;
            load_data <= '0;
        end else begin
            state    <= state_nxt;
            req_prev <= req;
            if (accept) begin
                cnt   <= '0;
                mis_q <= dec_mis;
                err_q <= 1'b0;
            end else if (state == S_ACCESS) begin
                if (bus_ready) begin
                    if (!we_q)
                        load_data <= extend_load(bus_rdata, addr_q[1:0], size_q, uns_q);
                end else if (to_hit) begin
                    err_q <= 1'b1;
                end else if (TO_EN) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Transaction payload captured at accept; only meaningful while busy
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= addr;
            be_q    <= dec_be;
            wdata_q <= dec_write ? dec_wdata : 32'b0;
            we_q    <= dec_write;
            size_q  <= dec_size;
            uns_q   <= dec_uns;
        end
    end

    // Bus outputs decode straight from state so reset drops them immediately.
    assign bus_req    = (state == S_ACCESS);
    assign bus_we     = bus_req & we_q;
    assign bus_addr   = bus_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus_be     = bus_req ? be_q : 4'b0;
    assign bus_wdata  = bus_req ? wdata_q : 32'b0;
    assign done       = (state == S_DONE);
    assign misaligned = done & mis_q;
    assign bus_err    = done & err_q;
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_read = 1'b0;
    logic [3:0]  mem_write = 4'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] addr = 32'b0;
    logic [31:0] store_data = 32'b0;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = 32'b0;
    logic        bus_req, bus_we, done, busy, misaligned, bus_err;
    logic [31:0] bus_addr, bus_wdata, load_data;
    logic [3:0]  bus_be;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .load_data(load_data), .done(done), .busy(busy),
        .misaligned(misaligned), .bus_err(bus_err)
    );

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 0;

    // Expected outputs for the current cycle
    logic        exp_req, exp_we, exp_done, exp_mis, exp_err, exp_busy;
    logic [31:0] exp_addr, exp_wdata, model_load;
    logic [3:0]  exp_be;

    // Observations from the most recent transaction, for literal checks
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we, cap_mis, cap_err, cap_done;
    int          req_cycles, extra_req;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("bus_req",    bus_req,    exp_req);
            check("bus_we",     bus_we,     exp_we);
            check("bus_addr",   bus_addr,   exp_addr);
            check("bus_be",     bus_be,     exp_be);
            check("bus_wdata",  bus_wdata,  exp_wdata);
            check("done",       done,       exp_done);
            check("misaligned", misaligned, exp_mis);
            check("bus_err",    bus_err,    exp_err);
            check("busy",       busy,       exp_busy);
            check("load_data",  load_data,  model_load);
        end
    end

    task automatic set_idle();
        exp_req = 0; exp_we = 0; exp_addr = 0; exp_be = 0; exp_wdata = 0;
        exp_done = 0; exp_mis = 0; exp_err = 0; exp_busy = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_bus();
        bus_ready = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
    endtask

    // One complete transaction; expectations come from the access rules:
    // width from mask/funct3, lanes from addr[1:0], one DONE cycle at the end.
    task automatic run_txn(input logic rd, input logic [3:0] wm, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input int wait_n,
                           input logic [31:0] rdat, input bit hold);
        int          nb;
        bit          wr, uns, mis, timed_out;
        logic [1:0]  off;
        logic [7:0]  b8;
        logic [15:0] h16;
        logic [31:0] ld;
        wr  = (wm != 4'b0);
        off = a[1:0];
        if (wr) nb = (wm == 4'b0001) ? 1 : (wm == 4'b0011) ? 2 : 4;
        else begin
            case (f3)
                3'd0, 3'd4: nb = 1;
                3'd1, 3'd5: nb = 2;
                default:    nb = 4;
            endcase
        end
        uns = !wr && (f3 == 3'd4 || f3 == 3'd5);
        mis = (nb == 2 && off[0]) || (nb == 4 && off != 2'b00);
        ld  = rdat;
        if (nb == 1) begin
            b8 = rdat[8*off +: 8];
            ld = uns ? {24'b0, b8} : {{24{b8[7]}}, b8};
        end else if (nb == 2 && !mis) begin
            h16 = rdat[8*off +: 16];
            ld = uns ? {16'b0, h16} : {{16{h16[15]}}, h16};
        end
        timed_out = 0;
        req_cycles = 0;
        extra_req = 0;

        // accept cycle
        mem_read = rd; mem_write = wm; funct3 = f3; addr = a; store_data = sd;
        rand_bus();
        set_idle();
        tick();
        if (!hold) begin mem_read = 0; mem_write = 0; end
        addr = $urandom; store_data = $urandom; funct3 = 3'($urandom);

        if (!mis) begin
            for (int k = 0; k < 64; k++) begin
                set_idle();
                exp_req = 1; exp_busy = 1; exp_we = wr;
                exp_addr  = {a[31:2], 2'b00};
                exp_be    = 4'(((1 << nb) - 1) << off);
                exp_wdata = wr ? (sd << (8 * off)) : 32'b0;
                bus_ready = (k == wait_n);
                bus_rdata = bus_ready ? rdat : $urandom;
                if (bus_req) req_cycles++;
                if (k == 0) begin
                    cap_addr = bus_addr; cap_be = bus_be; cap_wdata = bus_wdata; cap_we = bus_we;
                end
                tick();
                if (k == wait_n) begin
                    if (!wr) model_load = ld;
                    break;
                end
                if (k + 1 == TO) begin
                    timed_out = 1;
                    break;
                end
            end
        end

        // completion cycle
        set_idle();
        exp_done = 1; exp_busy = 1; exp_mis = mis; exp_err = timed_out;
        rand_bus();
        cap_done = done; cap_mis = misaligned; cap_err = bus_err;
        tick();

        set_idle();
        if (hold) begin
            for (int j = 0; j < 2; j++) begin
                rand_bus();
                if (bus_req || busy) extra_req++;
                tick();
            end
        end
        mem_read = 0; mem_write = 0;
        rand_bus();
        if (bus_req || busy) extra_req++;
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rdat, sd;
        logic        rd;
        logic [3:0]  wm;
        int          r;

        #1 rst_n = 0;
        #2;
        check("rst_bus_req",   bus_req,   32'd0);
        check("rst_busy",      busy,      32'd0);
        check("rst_done",      done,      32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_bus_be",    bus_be,    32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        model_load = 32'b0;
        set_idle();
        chk_en = 1;
        tick();

        // LW aligned, zero wait states
        run_txn(1, 4'b0000, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 0);
        check("lw_be",      cap_be,     32'hF);
        check("lw_addr",    cap_addr,   32'h100);
        check("lw_reqcyc",  req_cycles, 32'd1);
        check("lw_load",    load_data,  32'hDEADBEEF);

        // LB / LBU from the top byte lane
        run_txn(1, 4'b0000, 3'b000, 32'h103, 32'h0, 0, 32'h80112233, 0);
        check("lb_be",   cap_be,    32'h8);
        check("lb_load", load_data, 32'hFFFFFF80);
        run_txn(1, 4'b0000, 3'b100, 32'h103, 32'h0, 1, 32'h80112233, 0);
        check("lbu_load", load_data, 32'h00000080);

        // SH to the upper halfword
        run_txn(0, 4'b0011, 3'b001, 32'h202, 32'h0000ABCD, 0, 32'h0, 0);
        check("sh_we",    cap_we,    32'd1);
        check("sh_be",    cap_be,    32'hC);
        check("sh_wdata", cap_wdata, 32'hABCD0000);
        check("sh_addr",  cap_addr,  32'h200);
        check("sh_load_kept", load_data, 32'h00000080);

        // misaligned LW: no bus activity
        run_txn(1, 4'b0000, 3'b010, 32'h101, 32'h0, 0, 32'h12345678, 0);
        check("mis_reqcyc", req_cycles, 32'd0);
        check("mis_flag",   cap_mis,    32'd1);
        check("mis_done",   cap_done,   32'd1);

        // timeout with request level held afterwards
        run_txn(1, 4'b0000, 3'b001, 32'h204, 32'h0, 99, 32'h55555555, 1);
        check("to_reqcyc", req_cycles, 32'd4);
        check("to_err",    cap_err,    32'd1);
        check("to_load",   load_data,  32'h00000080);
        check("to_reissue", extra_req, 32'd0);

        // mem_read held across done with wait states: single access
        run_txn(1, 4'b0000, 3'b101, 32'h306, 32'h0, 2, 32'hF00D1234, 1);
        check("hold_reissue", extra_req, 32'd0);
        check("hold_load",    load_data, 32'h0000F00D);

        // store and load both asserted: write wins
        run_txn(1, 4'b1111, 3'b010, 32'h400, 32'hCAFEF00D, 0, 32'h11111111, 0);
        check("both_we",   cap_we,    32'd1);
        check("both_load", load_data, 32'h0000F00D);

        // reset in the middle of an ACCESS wait
        mem_read = 1; funct3 = 3'b010; addr = 32'h300; bus_ready = 0;
        set_idle();
        tick();
        exp_req = 1; exp_busy = 1; exp_addr = 32'h300; exp_be = 4'hF;
        tick();
        #2;
        chk_en = 0;
        rst_n = 0;
        #1;
        check("arst_bus_req", bus_req,   32'd0);
        check("arst_busy",    busy,      32'd0);
        check("arst_done",    done,      32'd0);
        check("arst_load",    load_data, 32'd0);
        model_load = 32'b0;
        mem_read = 0;
        #1 rst_n = 1;
        set_idle();
        tick();
        chk_en = 1;
        repeat (3) tick();

        // randomized transactions
        for (int i = 0; i < 80; i++) begin
            rd = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 3);
            wm = (r == 0) ? 4'b0000 : (r == 1) ? 4'b0001 : (r == 2) ? 4'b0011 : 4'b1111;
            if (!rd && wm == 4'b0) rd = 1;
            ra   = $urandom;
            rdat = $urandom;
            sd   = $urandom;
            run_txn(rd, wm, 3'($urandom), ra, sd, $urandom_range(0, 5), rdat,
                    1'($urandom_range(0, 1)));
        end

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
